ts_ordset_gen: RTL
==================

TS_ORDSET_GEN -- requirements
Module: ts_ordset_gen

Interface
REQ-001 SHALL have parameter TS_LEN, default 16, symbols per TS ordered set; fixed at 16.
REQ-002 SHALL have parameter SKP_INTERVAL, default 4, completed TS sets between SKP ordered sets (range 1..255).
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to begin a burst; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1, request to end a continuous or counted burst after the current ordered set.
REQ-007 SHALL have port ts_type, input, 1, 0=TS1, 1=TS2.
REQ-008 SHALL have port set_count, input, 16, number of TS sets to send; 0 = continuous until stop.
REQ-009 SHALL have ports nfts, dri, tc, input, 8 each, N_FTS, data-rate-identifier and training-control symbol values.
REQ-010 SHALL have port txdata, output, 8, transmitted symbol.
REQ-011 SHALL have port txdatak, output, 1, 1 = txdata is a K symbol.
REQ-012 SHALL have port en_n, output, 1, active-low transmit enable; 0 while any ordered set symbol is driven.
REQ-013 SHALL have ports busy (output, 1, high outside IDLE), done (output, 1, one-cycle end-of-burst pulse) and sent_ctr (output, 16, completed TS sets in the current burst).

Function
REQ-014 SHALL implement states IDLE, TS and SKP.
REQ-015 SHALL, in IDLE with start=1, latch ts_type, set_count, nfts, dri and tc, clear sent_ctr, and enter TS; the first COM appears on txdata the following cycle.
REQ-016 SHALL ignore start outside IDLE; latched fields SHALL NOT change mid-burst.
REQ-017 SHALL emit TS symbols 0..15 on consecutive cycles: 0xBC (K), 0xF7 (K, link PAD), 0xF7 (K, lane PAD), nfts, dri, tc, then ten identifiers, 0x4A for TS1 or 0x45 for TS2; symbols 3..15 SHALL have txdatak=0.
REQ-018 SHALL increment sent_ctr on the cycle symbol 15 is driven; sent_ctr SHALL wrap from 0xFFFF to 0x0000.
REQ-019 SHALL end the burst after symbol 15 when sent_ctr reaches a nonzero latched set_count, or when stop has been seen at any cycle since that set's COM.
REQ-020 SHALL otherwise start the next set's COM on the cycle immediately after symbol 15, with no gap.
REQ-021 SHALL, on burst end, enter IDLE, drive en_n=1, and pulse done=1 for exactly the first IDLE cycle.
REQ-022 SHALL drive txdata=0x00, txdatak=0, en_n=1 in IDLE; sent_ctr SHALL hold its final value until the next accepted start.
REQ-023 SHALL treat stop in IDLE as no-op; start and stop together in IDLE SHALL start a burst of exactly one set.

Reset
REQ-024 SHALL, while reset=1, set state IDLE, txdata=0x00, txdatak=0, en_n=1, busy=0, done=0, sent_ctr=0, latched fields=0.
REQ-025 SHALL abandon any partial ordered set when reset asserts mid-burst, without a done pulse; reset SHALL take priority over start.

Configuration
REQ-026 SHALL, with macro TS_ORDSET_GEN_SKP_EN defined, enter SKP after every SKP_INTERVAL completed TS sets when the burst is not ending, emitting 0xBC, 0x1C, 0x1C, 0x1C, all with txdatak=1 and en_n=0, then returning to TS.
REQ-027 SHALL NOT count SKP sets in sent_ctr; stop seen during SKP SHALL end the burst after the SKP set.
REQ-028 SHALL, without TS_ORDSET_GEN_SKP_EN, never enter SKP and contain no SKP logic.

Verification
REQ-029 SHALL cover: ts_type=0, set_count=2, nfts=0x12, dri=0x02, tc=0x00 -> 32 cycles BC,F7,F7,12,02,00,4Ax10 twice; done on cycle 33; sent_ctr=2.
REQ-030 SHALL cover: ts_type=1, set_count=1 -> identifiers 0x45; txdatak pattern 1,1,1 then 0x13; en_n high the cycle after symbol 15.
REQ-031 SHALL cover: set_count=0, stop asserted at symbol 7 of set 3 -> set 3 completes, sent_ctr=3, done pulses once.
REQ-032 SHALL cover: reset asserted at symbol 9 of set 1 -> next cycle txdata=0x00, en_n=1, sent_ctr=0, no done.
REQ-033 SHALL cover with TS_ORDSET_GEN_SKP_EN, SKP_INTERVAL=4, set_count=8 -> BC,1C,1C,1C after set 4 only, none after set 8; sent_ctr=8.
REQ-034 SHALL cover: start pulsed mid-burst with changed nfts=0x55 -> ignored; all sets carry the original nfts.

Source files
------------

// File: rtl/ts_ordset_gen.sv
// ts_ordset_gen: PCIe-style TS1/TS2 ordered-set burst generator.
// Optional SKP insertion every SKP_INTERVAL TS sets when TS_ORDSET_GEN_SKP_EN is defined.
module ts_ordset_gen #(
    parameter int TS_LEN       = 16,
    parameter int SKP_INTERVAL = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        ts_type,
    input  logic [15:0] set_count,
    input  logic [7:0]  nfts,
    input  logic [7:0]  dri,
    input  logic [7:0]  tc,
    output logic [7:0]  txdata,
    output logic        txdatak,
    output logic        en_n,
    output logic        busy,
    output logic        done,
    output logic [15:0] sent_ctr
);
    typedef enum logic [1:0] {IDLE, TS, SKP} state_t;

    if (TS_LEN != 16 || SKP_INTERVAL < 1 || SKP_INTERVAL > 255) begin : g_bad_cfg
        $error("ts_ordset_gen: unsupported TS_LEN or SKP_INTERVAL");
    end

    state_t      state_q, state_d;
    logic [3:0]  sym_q, sym_d;
    logic        type_q, type_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  nfts_q, nfts_d, dri_q, dri_d, tc_q, tc_d;
    logic [15:0] sent_q, sent_d;
    logic        stop_q, stop_d;
    logic        done_q, done_d;
    logic        last;
    logic [7:0]  ts_sym;
`ifdef TS_ORDSET_GEN_SKP_EN
    logic [7:0]  skp_q, skp_d;
`endif

    // stop is sticky per ordered set, so a one-cycle pulse anywhere in the set ends the burst
    assign last = (cnt_q != 16'd0 && sent_q + 16'd1 == cnt_q) || stop_q || stop;

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        type_d  = type_q;
        cnt_d   = cnt_q;
        nfts_d  = nfts_q;
        dri_d   = dri_q;
        tc_d    = tc_q;
        sent_d  = sent_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
`ifdef TS_ORDSET_GEN_SKP_EN
        skp_d   = skp_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                state_d = TS;
                sym_d   = 4'd0;
                type_d  = ts_type;
                cnt_d   = set_count;
                nfts_d  = nfts;
                dri_d   = dri;
                tc_d    = tc;
                sent_d  = 16'd0;
                stop_d  = stop;
`ifdef TS_ORDSET_GEN_SKP_EN
                skp_d   = 8'd0;
`endif
            end
            TS: begin
                sym_d  = sym_q + 4'd1;
                stop_d = stop_q | stop;
                if (sym_q == 4'(TS_LEN - 1)) begin
                    sent_d = sent_q + 16'd1;
                    stop_d = 1'b0;
                    if (last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
`ifdef TS_ORDSET_GEN_SKP_EN
                    else if (skp_q + 8'd1 == 8'(SKP_INTERVAL)) begin
                        state_d = SKP;
                        skp_d   = 8'd0;
                    end else
                        skp_d = skp_q + 8'd1;
`endif
                end
            end
`ifdef TS_ORDSET_GEN_SKP_EN
            SKP: begin
                sym_d  = sym_q + 4'd1;
                stop_d = stop_q | stop;
                if (sym_q == 4'd3) begin
                    sym_d   = 4'd0;
                    stop_d  = 1'b0;
                    state_d = (stop_q | stop) ? IDLE : TS;
                    done_d  = stop_q | stop;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sym_q   <= 4'd0;
            type_q  <= 1'b0;
            cnt_q   <= 16'd0;
            nfts_q  <= 8'd0;
            dri_q   <= 8'd0;
            tc_q    <= 8'd0;
            sent_q  <= 16'd0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef TS_ORDSET_GEN_SKP_EN
            skp_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            type_q  <= type_d;
            cnt_q   <= cnt_d;
            nfts_q  <= nfts_d;
            dri_q   <= dri_d;
            tc_q    <= tc_d;
            sent_q  <= sent_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
`ifdef TS_ORDSET_GEN_SKP_EN
            skp_q   <= skp_d;
`endif
        end
    end

    assign ts_sym = sym_q == 4'd0 ? 8'hBC :
                    sym_q < 4'd3  ? 8'hF7 :
                    sym_q == 4'd3 ? nfts_q :
                    sym_q == 4'd4 ? dri_q :
                    sym_q == 4'd5 ? tc_q :
                    type_q        ? 8'h45 : 8'h4A;
`ifdef TS_ORDSET_GEN_SKP_EN
    assign txdata  = state_q == TS  ? ts_sym :
                     state_q == SKP ? (sym_q == 4'd0 ? 8'hBC : 8'h1C) : 8'h00;
    assign txdatak = state_q == TS ? sym_q < 4'd3 : state_q == SKP;
`else
    assign txdata  = state_q == TS ? ts_sym : 8'h00;
    assign txdatak = state_q == TS && sym_q < 4'd3;
`endif
    assign en_n     = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign sent_ctr = sent_q;
endmodule
